// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment frame reader: segment patterns,
// blank code, FSM state encoding and default debounce length.
package seg_pkg;

    localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Index into this table is the hex value the pattern represents (bit6=a .. bit0=g).
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } seg_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to hex nibble decoder with legality
// and blank flags.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       blank
);

    always_comb begin
        nibble = '0;
        legal  = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (seg == SEG_PATTERNS[i]) begin
                nibble = 4'(i);
                legal  = 1'b1;
            end
        end
    end

    assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seven_segment_reader.sv
// Reads a multiplexed four-digit seven-segment display: debounces each
// (seg, an) pair, decodes digits and publishes complete 16-bit frames.
module seven_segment_reader
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        err,
    output logic        busy
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic [CW-1:0] cnt;
    logic          strobe;
    logic          pair_same;

    seg_state_t    state, state_n;
    logic [3:0]    mask, mask_n;
    logic [15:0]   shadow, shadow_n;
    logic [15:0]   value_n;
    logic          load, err_n;

    logic [3:0]    dec_nibble;
    logic          dec_legal, dec_blank;
    logic          an_onehot;

    assign pair_same = (seg == seg_q) && (an == an_q);

    // Strobe is registered on the edge the counter reaches STABLE_CYCLES, so the
    // capture acts one edge later on the still-registered stable pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q  <= '0;
            an_q   <= '0;
            cnt    <= '0;
            strobe <= 1'b0;
        end else begin
            seg_q  <= seg;
            an_q   <= an;
            strobe <= pair_same && (cnt == CNT_LAST);
            if (!pair_same)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_ONE;
        end
    end

    seg_pattern_decode u_decode (
        .seg    (seg_q),
        .nibble (dec_nibble),
        .legal  (dec_legal),
        .blank  (dec_blank)
    );

    always_comb begin
        case (an_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: an_onehot = 1'b1;
            default:                            an_onehot = 1'b0;
        endcase
    end

    always_comb begin
        state_n  = state;
        mask_n   = mask;
        shadow_n = shadow;
        value_n  = value;
        load     = 1'b0;
        err_n    = 1'b0;

        // Mask is already cleared on DONE entry, so a capture here opens a new frame.
        if (state == ST_DONE)
            state_n = ST_IDLE;

        if (strobe && an_onehot && !dec_blank) begin
            if (dec_legal) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (an_q[i])
                        shadow_n[i*4 +: 4] = dec_nibble;
                end
                mask_n = mask | an_q;
                if (mask_n == 4'hF) begin
                    value_n  = shadow_n;
                    load     = 1'b1;
                    mask_n   = '0;
                    shadow_n = '0;
                    state_n  = ST_DONE;
                end else begin
                    state_n  = ST_COLLECT;
                end
            end else begin
                err_n    = 1'b1;
                mask_n   = '0;
                shadow_n = '0;
                state_n  = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mask   <= '0;
            shadow <= '0;
            value  <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            mask   <= mask_n;
            shadow <= shadow_n;
            err    <= err_n;
            if (load)
                value <= value_n;
        end
    end

    assign value_valid = (state == ST_DONE);
    assign busy        = |mask;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader against a run-length based
// behavioural model of the display reader.
module tb_seven_segment_reader;

    localparam int unsigned SC = 4;

    localparam logic [6:0] TBL [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = '0;
    logic [3:0]  an = '0;
    logic [15:0] value;
    logic        value_valid, err, busy;

    seven_segment_reader #(.STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .value_valid (value_valid),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [15:0] m_value;
    logic        m_valid, m_err;
    logic [3:0]  m_mask;
    logic [3:0]  m_shadow [4];
    logic [10:0] last_pair, pend_pair;
    int          run;
    bit          pend;

    task automatic apply_capture(input logic [10:0] p);
        logic [6:0] s;
        logic [3:0] a;
        int d, nib;
        s = p[10:4];
        a = p[3:0];
        d = -1;
        for (int k = 0; k < 4; k++)
            if (a == (4'b0001 << k)) d = k;
        if (d < 0 || s == 7'b0000000) return;
        nib = -1;
        for (int k = 0; k < 16; k++)
            if (TBL[k] == s) nib = k;
        if (nib >= 0) begin
            m_shadow[d] = 4'(nib);
            m_mask[d]   = 1'b1;
            if (m_mask == 4'hF) begin
                m_value = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
                m_valid = 1'b1;
                m_mask  = '0;
            end
        end else begin
            m_err  = 1'b1;
            m_mask = '0;
            for (int k = 0; k < 4; k++) m_shadow[k] = '0;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_value = '0; m_valid = 0; m_err = 0; m_mask = '0;
            for (int k = 0; k < 4; k++) m_shadow[k] = '0;
            last_pair = '0; run = 1; pend = 0; pend_pair = '0;
        end else begin
            m_valid = 0;
            m_err   = 0;
            if (pend) begin
                pend = 0;
                apply_capture(pend_pair);
            end
            if ({seg, an} == last_pair) begin
                if (run == SC) begin
                    run = SC + 1;
                    pend = 1;
                    pend_pair = last_pair;
                end else if (run < SC) begin
                    run++;
                end
            end else begin
                last_pair = {seg, an};
                run = 1;
            end
        end
    end

    // ---------------- compare process ----------------
    int          checks = 0;
    int          errors = 0;
    int          lit_seq = 0;
    int          lit_done = 0;
    logic [15:0] lit_exp;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_value", value, 16'h0000);
            chk("reset_valid", 16'(value_valid), 16'h0);
            chk("reset_err",   16'(err), 16'h0);
            chk("reset_busy",  16'(busy), 16'h0);
        end else begin
            chk("value", value, m_value);
            chk("value_valid", 16'(value_valid), 16'(m_valid));
            chk("err", 16'(err), 16'(m_err));
            chk("busy", 16'(busy), 16'(m_mask != 4'h0));
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            chk("pin_dut_value", value, lit_exp);
            chk("pin_model_value", m_value, lit_exp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pin(input logic [15:0] v);
        lit_exp = v;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        an = '0;
        seg = '0;
        repeat (n) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] ra;
        logic [6:0] rs;
        int r;

        do_reset(3);

        // full frame 1A43
        hold(4'b0001, 7'b1111001, 6);
        hold(4'b0010, 7'b0110011, 6);
        hold(4'b0100, 7'b1110111, 6);
        hold(4'b1000, 7'b0110000, 6);
        hold(4'b0000, 7'b0000000, 3);
        pin(16'h1A43);

        // too short to capture
        hold(4'b0001, 7'b1111110, 3);
        hold(4'b0000, 7'b0000000, 2);

        // non-one-hot select and blank pattern are ignored
        hold(4'b0011, 7'b1111110, 10);
        hold(4'b0001, 7'b0000000, 10);

        // illegal pattern aborts a partial frame
        hold(4'b0001, 7'b0110000, 6);
        hold(4'b0010, 7'b1101101, 6);
        hold(4'b0100, 7'b1010101, 6);
        hold(4'b0000, 7'b0000000, 3);
        pin(16'h1A43);

        // digit 0 overwritten before completion: 5 then 9
        hold(4'b0001, 7'b1011011, 6);
        hold(4'b0001, 7'b1111011, 6);
        hold(4'b0010, 7'b1111110, 6);
        hold(4'b0100, 7'b1110000, 6);
        hold(4'b1000, 7'b1111111, 6);
        hold(4'b0000, 7'b0000000, 3);
        pin(16'h8709);

        // reset mid-frame, then a fresh frame FEC2
        hold(4'b0001, 7'b0110000, 6);
        hold(4'b0010, 7'b0110000, 6);
        hold(4'b0100, 7'b0110000, 6);
        do_reset(2);
        hold(4'b0000, 7'b0000000, 2);
        hold(4'b1000, 7'b1000111, 6);
        hold(4'b0001, 7'b1101101, 6);
        hold(4'b0010, 7'b1001110, 6);
        hold(4'b0100, 7'b1001111, 6);
        hold(4'b0000, 7'b0000000, 3);
        pin(16'hFEC2);

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       ra = 4'b0001 << $urandom_range(0, 3);
            else if (r == 7) ra = 4'b0000;
            else             ra = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 19);
            if (r < 16)       rs = TBL[r];
            else if (r == 16) rs = 7'b0000000;
            else              rs = 7'($urandom_range(0, 127));
            hold(ra, rs, $urandom_range(1, 8));
            if (it % 97 == 96) do_reset(2);
        end

        hold(4'b0000, 7'b0000000, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
